// File: rtl/control_fsm_pkg.sv
// Shared constants for the multi-cycle main control unit: opcodes, ALUOP codes,
// state and instruction-class enums, plus per-class ALU setup helpers.
package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    MEM,
    WB
  } ctrlState_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_ILLEGAL
  } instrClass_t;

  // ALUOP and ALUSrc are fixed per class from EXEC onwards.
  function automatic logic [1:0] aluOpFor(instrClass_t cls);
    case (cls)
      CLS_RTYPE: return ALU_FUNCT;
      CLS_BEQ:   return ALU_SUB;
      default:   return ALU_ADD;
    endcase
  endfunction

  function automatic logic aluSrcFor(instrClass_t cls);
    return (cls == CLS_ADDI) || (cls == CLS_LW) || (cls == CLS_SW);
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Handshake and datapath-control bundle between instruction fetch (master)
// and the main control unit (slave).
interface control_fsm_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instruction;
  logic        RegDst;
  logic        Branch;
  logic        MemRead;
  logic        MemtoReg;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic [1:0]  ALUOP;
  logic        done;
  logic        illegal;

  modport master (
    output instr_valid, Instruction,
    input  instr_ready, RegDst, Branch, MemRead, MemtoReg, MemWrite,
           ALUSrc, RegWrite, ALUOP, done, illegal
  );

  modport slave (
    input  instr_valid, Instruction,
    output instr_ready, RegDst, Branch, MemRead, MemtoReg, MemWrite,
           ALUSrc, RegWrite, ALUOP, done, illegal
  );
endinterface

// File: rtl/control_fsm_decoder.sv
// Combinational opcode classifier; anything outside the five supported
// opcodes is reported as illegal.
import control_pkg::*;

module control_decoder (
  input  logic [5:0]  i_opcode,
  output instrClass_t o_class,
  output logic        o_illegal
);

  always_comb begin
    o_class   = CLS_ILLEGAL;
    o_illegal = 1'b1;
    case (i_opcode)
      OP_RTYPE: begin o_class = CLS_RTYPE; o_illegal = 1'b0; end
      OP_ADDI:  begin o_class = CLS_ADDI;  o_illegal = 1'b0; end
      OP_LW:    begin o_class = CLS_LW;    o_illegal = 1'b0; end
      OP_SW:    begin o_class = CLS_SW;    o_illegal = 1'b0; end
      OP_BEQ:   begin o_class = CLS_BEQ;   o_illegal = 1'b0; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle main control unit: accepts one instruction in IDLE, then walks
// DECODE/EXEC/MEM/WB driving registered datapath control signals.
import control_pkg::*;

module control_fsm (
  input logic           i_clk,
  input logic           i_rst,
  control_fsm_if.slave  bus
);

  ctrlState_t  r_state;
  instrClass_t r_class;
  logic [5:0]  r_opcode;

  logic        r_ready;
  logic        r_regDst;
  logic        r_branch;
  logic        r_memRead;
  logic        r_memtoReg;
  logic        r_memWrite;
  logic        r_aluSrc;
  logic        r_regWrite;
  logic [1:0]  r_aluOp;
  logic        r_done;
  logic        r_illegal;

  logic [5:0]  w_decOpcode;
  instrClass_t w_class;
  logic        w_illegal;
  logic        w_unusedBits;

  // Only the opcode field steers control; the rest of the word belongs to the datapath.
  assign w_unusedBits = ^bus.Instruction[25:0];
  assign w_decOpcode  = (r_state == IDLE) ? bus.Instruction[31:26] : r_opcode;

  control_decoder u_decoder (
    .i_opcode  (w_decOpcode),
    .o_class   (w_class),
    .o_illegal (w_illegal)
  );

  // Output registers are loaded with the values of the state being entered,
  // so every output is a pure function of the current state and latched class.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_class    <= CLS_RTYPE;
      r_opcode   <= 6'b000000;
      r_ready    <= 1'b1;
      r_regDst   <= 1'b0;
      r_branch   <= 1'b0;
      r_memRead  <= 1'b0;
      r_memtoReg <= 1'b0;
      r_memWrite <= 1'b0;
      r_aluSrc   <= 1'b0;
      r_regWrite <= 1'b0;
      r_aluOp    <= ALU_ADD;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_ready    <= 1'b0;
      r_regDst   <= 1'b0;
      r_branch   <= 1'b0;
      r_memRead  <= 1'b0;
      r_memtoReg <= 1'b0;
      r_memWrite <= 1'b0;
      r_aluSrc   <= 1'b0;
      r_regWrite <= 1'b0;
      r_aluOp    <= ALU_ADD;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (bus.instr_valid) begin
            r_opcode  <= bus.Instruction[31:26];
            r_class   <= w_class;
            r_illegal <= w_illegal;
            r_state   <= DECODE;
          end else begin
            r_ready <= 1'b1;
          end
        end

        DECODE: begin
          if (r_class == CLS_ILLEGAL) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_aluOp  <= aluOpFor(r_class);
            r_aluSrc <= aluSrcFor(r_class);
            r_branch <= (r_class == CLS_BEQ);
            r_done   <= (r_class == CLS_BEQ);
            r_state  <= EXEC;
          end
        end

        EXEC: begin
          if (r_class == CLS_BEQ) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end else if (r_class == CLS_LW || r_class == CLS_SW) begin
            r_aluOp    <= aluOpFor(r_class);
            r_aluSrc   <= aluSrcFor(r_class);
            r_memRead  <= (r_class == CLS_LW);
            r_memWrite <= (r_class == CLS_SW);
            r_done     <= (r_class == CLS_SW);
            r_state    <= MEM;
          end else begin
            r_aluOp    <= aluOpFor(r_class);
            r_aluSrc   <= aluSrcFor(r_class);
            r_regWrite <= 1'b1;
            r_regDst   <= (r_class == CLS_RTYPE);
            r_done     <= 1'b1;
            r_state    <= WB;
          end
        end

        MEM: begin
          if (r_class == CLS_LW) begin
            r_aluOp    <= aluOpFor(r_class);
            r_aluSrc   <= aluSrcFor(r_class);
            r_regWrite <= 1'b1;
            r_memtoReg <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= WB;
          end else begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end

        WB: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end

        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready = r_ready;
  assign bus.RegDst      = r_regDst;
  assign bus.Branch      = r_branch;
  assign bus.MemRead     = r_memRead;
  assign bus.MemtoReg    = r_memtoReg;
  assign bus.MemWrite    = r_memWrite;
  assign bus.ALUSrc      = r_aluSrc;
  assign bus.RegWrite    = r_regWrite;
  assign bus.ALUOP       = r_aluOp;
  assign bus.done        = r_done;
  assign bus.illegal     = r_illegal;

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm: every state of every
// instruction class is compared against a hand-computed control vector.
module tb_control_fsm;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  control_fsm_if bus ();

  control_fsm dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: ready, RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOP[1:0], done, illegal
  logic [11:0] obs;
  assign obs = {bus.instr_ready, bus.RegDst, bus.Branch, bus.MemRead, bus.MemtoReg,
                bus.MemWrite, bus.ALUSrc, bus.RegWrite, bus.ALUOP, bus.done, bus.illegal};

  function automatic logic [11:0] ctl(input logic rdy, input logic rd, input logic br,
                                      input logic mr, input logic m2r, input logic mw,
                                      input logic as, input logic rw, input logic [1:0] op,
                                      input logic dn, input logic il);
    return {rdy, rd, br, mr, m2r, mw, as, rw, op, dn, il};
  endfunction

  localparam logic [11:0] V_IDLE   = 12'b1000_0000_0000;
  localparam logic [11:0] V_DECODE = 12'b0000_0000_0000;

  task automatic checkOutput(input string tag, input logic [11:0] actual, input logic [11:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr);
    bus.instr_valid = valid;
    bus.Instruction = instr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0);
    #1;
    checkOutput("reset_state", obs, V_IDLE);
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("idle_after_reset", obs, V_IDLE);

    // lw interrupted by reset while in MEM
    applyStimulus(1'b1, 32'h8C084200);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkOutput("lwr_decode", obs, V_DECODE);
    tick();
    checkOutput("lwr_exec", obs, ctl(0,0,0,0,0,0,1,0,2'b00,0,0));
    tick();
    checkOutput("lwr_mem", obs, ctl(0,0,0,1,0,0,1,0,2'b00,0,0));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", obs, V_IDLE);
    #3;
    rst = 1'b0;
    tick();
    checkOutput("post_reset_idle", obs, V_IDLE);
    tick();
    checkOutput("post_reset_no_rw", obs, V_IDLE);

    // R-type
    applyStimulus(1'b1, 32'h00004200);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkOutput("r_decode", obs, V_DECODE);
    tick();
    checkOutput("r_exec", obs, ctl(0,0,0,0,0,0,0,0,2'b10,0,0));
    tick();
    checkOutput("r_wb", obs, ctl(0,1,0,0,0,0,0,1,2'b10,1,0));
    tick();
    checkOutput("r_idle", obs, V_IDLE);

    // addi
    applyStimulus(1'b1, 32'h20084200);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkOutput("addi_decode", obs, V_DECODE);
    tick();
    checkOutput("addi_exec", obs, ctl(0,0,0,0,0,0,1,0,2'b00,0,0));
    tick();
    checkOutput("addi_wb", obs, ctl(0,0,0,0,0,0,1,1,2'b00,1,0));
    tick();
    checkOutput("addi_idle", obs, V_IDLE);

    // lw then sw back to back; valid stays high through lw and must not queue
    applyStimulus(1'b1, 32'h8C084200);
    tick();
    applyStimulus(1'b1, 32'hAC084200);
    checkOutput("lw_decode", obs, V_DECODE);
    tick();
    checkOutput("lw_exec", obs, ctl(0,0,0,0,0,0,1,0,2'b00,0,0));
    tick();
    checkOutput("lw_mem", obs, ctl(0,0,0,1,0,0,1,0,2'b00,0,0));
    tick();
    checkOutput("lw_wb", obs, ctl(0,0,0,0,1,0,1,1,2'b00,1,0));
    tick();
    checkOutput("lw_to_idle", obs, V_IDLE);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkOutput("sw_decode", obs, V_DECODE);
    tick();
    checkOutput("sw_exec", obs, ctl(0,0,0,0,0,0,1,0,2'b00,0,0));
    tick();
    checkOutput("sw_mem", obs, ctl(0,0,0,0,0,1,1,0,2'b00,1,0));
    tick();
    checkOutput("sw_idle", obs, V_IDLE);

    // beq
    applyStimulus(1'b1, 32'h10084200);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkOutput("beq_decode", obs, V_DECODE);
    tick();
    checkOutput("beq_exec", obs, ctl(0,0,1,0,0,0,0,0,2'b01,1,0));
    tick();
    checkOutput("beq_idle", obs, V_IDLE);

    // illegal opcode 111111
    applyStimulus(1'b1, 32'hFC004200);
    tick();
    applyStimulus(1'b0, 32'h0);
    checkOutput("ill_decode", obs, ctl(0,0,0,0,0,0,0,0,2'b00,0,1));
    tick();
    checkOutput("ill_idle", obs, V_IDLE);
    tick();
    checkOutput("idle_hold", obs, V_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
